// File: rtl/systolic_west_feeder.sv
// West-edge feeder for an N-row systolic array: buffers one K-column tile of A,
// then replays it with a diagonal skew (row i delayed i-1 cycles), zero-padded.
//
// state  | meaning
// S_FILL | accepting A-columns into the tile buffer (in_ready=1)
// S_EMIT | streaming the buffered tile, K+N-1 cycles, input frozen
// S_DONE | one-cycle done pulse, outputs zero
module systolic_west_feeder #(
  parameter int N     = 4,
  parameter int WDATA = 4,
  parameter int K     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N:1][WDATA-1:0]      in_data,
  output logic [N:1][WDATA-1:0]      feed_W,
  output logic [N:1]                 lane_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int TLAST = K + N - 2;
  localparam int TW    = (K + N - 1 > 1) ? $clog2(K + N - 1) : 1;
  localparam int CW    = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {S_FILL, S_EMIT, S_DONE} state_t;

  state_t                r_state, w_state_nx;
  logic [CW-1:0]         r_wr_cnt;
  logic [TW-1:0]         r_t, w_t_nx;
  logic [WDATA-1:0]      r_buf    [1:N][0:K-1];
  logic [WDATA-1:0]      w_buf_nx [1:N][0:K-1];
  logic [N:1][WDATA-1:0] w_feed_nx;
  logic [N:1]            w_lv_nx;
  logic                  w_hs, w_last_col, w_last_t;

  // in_ready is gated by rst so it reads 0 while reset is held, not just after.
  assign in_ready   = (r_state == S_FILL) && !rst;
  assign w_hs       = in_valid && in_ready;
  assign w_last_col = (r_wr_cnt == CW'(K - 1));
  assign w_last_t   = (r_t == TW'(TLAST));
  assign busy       = (r_state == S_EMIT);
  assign done       = (r_state == S_DONE);

  always_comb begin
    w_state_nx = r_state;
    w_t_nx     = r_t;
    case (r_state)
      S_FILL: begin
        if (w_hs && w_last_col) begin
          w_state_nx = S_EMIT;
          w_t_nx     = '0;
        end
      end
      S_EMIT: begin
        if (w_last_t) begin
          w_state_nx = S_DONE;
          w_t_nx     = '0;
        end else begin
          w_t_nx = r_t + TW'(1);
        end
      end
      S_DONE: begin
        w_state_nx = S_FILL;
        w_t_nx     = '0;
      end
      default: begin
        w_state_nx = S_FILL;
        w_t_nx     = '0;
      end
    endcase
  end

  // Write-through view of the buffer, so the first EMIT cycle can show a column
  // that is being written on the same edge (matters for K=1).
  always_comb begin
    w_buf_nx = r_buf;
    if (w_hs) begin
      for (int i = 1; i <= N; i++) w_buf_nx[i][r_wr_cnt] = in_data[i];
    end
  end

  always_comb begin
    w_feed_nx = '0;
    w_lv_nx   = '0;
    if (w_state_nx == S_EMIT) begin
      for (int i = 1; i <= N; i++) begin
        for (int k = 0; k < K; k++) begin
          if (w_t_nx == TW'(k + i - 1)) begin
            w_feed_nx[i] = w_buf_nx[i][k];
            w_lv_nx[i]   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FILL;
      r_wr_cnt   <= '0;
      r_t        <= '0;
      feed_W     <= '0;
      lane_valid <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_t        <= w_t_nx;
      feed_W     <= w_feed_nx;
      lane_valid <= w_lv_nx;
      if (w_hs) r_wr_cnt <= w_last_col ? '0 : r_wr_cnt + CW'(1);
    end
  end

  // Buffer needs no reset: it is always rewritten in FILL before being emitted.
  always_ff @(posedge clk) begin
    r_buf <= w_buf_nx;
  end

endmodule
